round_pipe: RTL and testbench

//  Rounds a wide I/Q sample pair (e.g. DDC/CIC output) down to bits_out+1 bits, feeding the clip macro.
//  The extra MSB preserves round-up carry, so the clip macro, not this block, does saturation to bits_out.
//  Two-stage registered pipeline with valid/ready flow control; full rate, no bubbles, lossless backpressure.

---
 rtl/round_pipe_if.sv | 33 +++
 rtl/round_pipe.sv | 147 ++++++++++++++
 tb/tb_round_pipe.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/round_pipe_if.sv
// ---------------------------------------------------------------------------
// round_pipe_if
// Bundles the sample stream into and out of round_pipe.
//   master : the side that feeds samples in and accepts results
//            (drives in_i, in_q, in_valid, out_ready)
//   slave  : the rounding block itself
//            (drives in_ready, out_i, out_q, out_valid)
// Parameters mirror round_pipe: bits_in per rail on the input side,
// bits_out+1 per rail on the output side.
// ---------------------------------------------------------------------------
interface round_pipe_if #(
    parameter int bits_in  = 24,
    parameter int bits_out = 16
);
    logic [bits_in-1:0] in_i;
    logic [bits_in-1:0] in_q;
    logic               in_valid;
    logic               in_ready;
    logic [bits_out:0]  out_i;
    logic [bits_out:0]  out_q;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_i, in_q, in_valid, out_ready,
        input  in_ready, out_i, out_q, out_valid
    );

    modport slave (
        input  in_i, in_q, in_valid, out_ready,
        output in_ready, out_i, out_q, out_valid
    );
endinterface

// File: rtl/round_pipe.sv
// ---------------------------------------------------------------------------
// round_pipe
// Rounds a wide two's-complement I/Q pair down to bits_out+1 bits for the
// downstream clip block. The extra MSB keeps the round-up carry, so
// saturation to bits_out happens in the clip block, not here.
// Two registered stages with valid/ready flow control: full rate, no
// bubbles, lossless backpressure; I and Q share one handshake.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset (release synchronised externally)
//   bus    : round_pipe_if.slave
//            in_i/in_q   [bits_in-1:0]  input samples
//            in_valid/in_ready          input handshake
//            out_i/out_q [bits_out:0]   rounded samples (registered)
//            out_valid/out_ready        output handshake
//
// Configuration macro: ROUND_PIPE_CONVERGENT_EN
//   undefined : round half up (toward +inf), half-LSB always added
//   defined   : exact ties round to even, other values as above
// Pipeline depth and handshake are identical in both builds.
//
// D = bits_in-bits_out-1 LSBs are discarded; bits_in >= bits_out+2 required.
// ---------------------------------------------------------------------------
module round_pipe #(
    parameter int bits_in  = 24,
    parameter int bits_out = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    round_pipe_if.slave  bus
);
    localparam int D = bits_in - bits_out - 1;

    typedef logic [bits_in:0]  ext_t;
    typedef logic [bits_out:0] out_t;

    // Half of one output LSB, at full input precision.
    localparam ext_t H = {{bits_in{1'b0}}, 1'b1} << (D - 1);

    // Add the (optional) half LSB and keep the output field. The sum is
    // bits_in+1 wide; its top bit is only the sign extension and is dropped
    // so the result fits the bits_out+1 output, carry included.
    function automatic out_t round_rail(input ext_t x, input logic add_half);
        return out_t'((x + (add_half ? H : {(bits_in+1){1'b0}})) >> D);
    endfunction

`ifdef ROUND_PIPE_CONVERGENT_EN
    // A tie means the discarded bits are exactly one half LSB.
    function automatic logic is_tie(input logic [bits_in-1:0] x);
        return (x[D-1:0] == H[D-1:0]);
    endfunction
`endif

    ext_t s1_i_r;
    ext_t s1_q_r;
    logic s1_valid_r;
`ifdef ROUND_PIPE_CONVERGENT_EN
    logic s1_i_tie_r;
    logic s1_q_tie_r;
    logic s1_i_lsb_r;
    logic s1_q_lsb_r;
`endif

    out_t s2_i_r;
    out_t s2_q_r;
    logic s2_valid_r;

    logic s1_take_s;
    logic s2_take_s;
    logic add_i_s;
    logic add_q_s;

    // A stage may load when it is empty or its content leaves this cycle.
    always_comb begin
        s2_take_s = ~s2_valid_r | bus.out_ready;
        s1_take_s = ~s1_valid_r | s2_take_s;
    end

    // Per-rail decision whether the half LSB is added in stage 2.
    always_comb begin
        add_i_s = 1'b1;
        add_q_s = 1'b1;
`ifdef ROUND_PIPE_CONVERGENT_EN
        // On a tie only round up when the kept LSB is odd (round to even).
        if (s1_i_tie_r) begin
            add_i_s = s1_i_lsb_r;
        end else begin
            add_i_s = 1'b1;
        end
        if (s1_q_tie_r) begin
            add_q_s = s1_q_lsb_r;
        end else begin
            add_q_s = 1'b1;
        end
`endif
    end

    // Stage 1: capture sign-extended samples and rounding flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_i_r     <= {(bits_in+1){1'b0}};
            s1_q_r     <= {(bits_in+1){1'b0}};
`ifdef ROUND_PIPE_CONVERGENT_EN
            s1_i_tie_r <= 1'b0;
            s1_q_tie_r <= 1'b0;
            s1_i_lsb_r <= 1'b0;
            s1_q_lsb_r <= 1'b0;
`endif
        end else if (s1_take_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_i_r     <= {bus.in_i[bits_in-1], bus.in_i};
                s1_q_r     <= {bus.in_q[bits_in-1], bus.in_q};
`ifdef ROUND_PIPE_CONVERGENT_EN
                s1_i_tie_r <= is_tie(bus.in_i);
                s1_q_tie_r <= is_tie(bus.in_q);
                s1_i_lsb_r <= bus.in_i[D];
                s1_q_lsb_r <= bus.in_q[D];
`endif
            end
        end
    end

    // Stage 2: register the rounded results; this is the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_i_r     <= {(bits_out+1){1'b0}};
            s2_q_r     <= {(bits_out+1){1'b0}};
        end else if (s2_take_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_i_r <= round_rail(s1_i_r, add_i_s);
                s2_q_r <= round_rail(s1_q_r, add_q_s);
            end
        end
    end

    // in_ready is the stage-1 load condition and never looks at in_valid.
    assign bus.in_ready  = s1_take_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_i     = s2_i_r;
    assign bus.out_q     = s2_q_r;

endmodule

// File: tb/tb_round_pipe.sv
// ---------------------------------------------------------------------------
// tb_round_pipe
// Directed bench for round_pipe (bits_in=24, bits_out=16, D=7, 17-bit out).
// Expected results are computed from the input with integer arithmetic and
// queued when a sample is accepted; a negedge monitor pops and compares them
// whenever the DUT hands a sample downstream. The monitor also checks that
// stalled outputs hold and that in_ready drops only with both stages full.
// Build with +define+ROUND_PIPE_CONVERGENT_EN to check the round-to-even build.
// ---------------------------------------------------------------------------
module tb_round_pipe;
    localparam int BI = 24;
    localparam int BO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    round_pipe_if #(.bits_in(BI), .bits_out(BO)) bus ();

    round_pipe #(.bits_in(BI), .bits_out(BO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp      = 0;
    int          n_bad      = 0;
    int          n_out      = 0;
    int          stall_left = 0;
    logic        rand_rdy   = 1'b0;
    logic [33:0] exp_q[$];

    logic        prev_hold = 1'b0;
    logic [16:0] prev_i    = 17'd0;
    logic [16:0] prev_q    = 17'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference rounding by integer arithmetic on the signed input value.
    function automatic logic [16:0] model(input logic [23:0] x);
        int v;
        int r;
        v = $signed(x);
`ifdef ROUND_PIPE_CONVERGENT_EN
        if (((v & 127) == 64) && (((v >>> 7) & 1) == 0)) r = v >>> 7;
        else                                              r = (v + 64) >>> 7;
`else
        r = (v + 64) >>> 7;
`endif
        return r[16:0];
    endfunction

    // Scoreboard and flow-control monitor, sampled away from the active edge.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst_n) begin
            exp_q.delete();
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_i", bus.out_i, prev_i);
                check("hold_q", bus.out_q, prev_q);
            end
            check("in_ready", bus.in_ready,
                  ((exp_q.size() == 2) && !bus.out_ready) ? 0 : 1);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_i", bus.out_i, e[33:17]);
                    check("sb_out_q", bus.out_q, e[16:0]);
                    n_out++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back({model(bus.in_i), model(bus.in_q)});
            prev_hold <= bus.out_valid && !bus.out_ready;
            prev_i    <= bus.out_i;
            prev_q    <= bus.out_q;
        end
    end

    // Present one sample and hold it until accepted (bounded wait).
    task automatic send(input logic [23:0] vi, input logic [23:0] vq);
        int   guard;
        logic acc;
        guard      = 0;
        acc        = 1'b0;
        bus.in_i   = vi;
        bus.in_q   = vq;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else if (rand_rdy) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check("send_timeout", guard, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          base;
        int          guard;
        logic [23:0] ramp;
        bus.in_i      = 24'd0;
        bus.in_q      = 24'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_i", bus.out_i, 0);
        check("rst_out_q", bus.out_q, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        // 1: 3.0 then 1.5, two-cycle latency
        send(24'h000180, 24'h000000);
        check("t1_lat_early", bus.out_valid, 0);
        send(24'h0000C0, 24'h000000);
        check("t1_valid_a", bus.out_valid, 1);
        check("t1_out_a", bus.out_i, 17'h00003);
        tick();
        check("t1_valid_b", bus.out_valid, 1);
        check("t1_out_b", bus.out_i, 17'h00002);
        tick();

        // 2: ties 2.5 and -1.5
        send(24'h000140, 24'h000000);
        send(24'hFFFF40, 24'h000000);
`ifdef ROUND_PIPE_CONVERGENT_EN
        check("t2_tie_pos", bus.out_i, 17'h00002);
        tick();
        check("t2_tie_neg", bus.out_i, 17'h1FFFE);
`else
        check("t2_tie_pos", bus.out_i, 17'h00003);
        tick();
        check("t2_tie_neg", bus.out_i, 17'h1FFFF);
`endif
        tick();

        // 3: extremes carry into the extra MSB
        send(24'h7FFFFF, 24'h800000);
        send(24'h800000, 24'h7FFFFF);
        check("t3_max_i", bus.out_i, 17'h10000);
        check("t3_min_q", bus.out_q, 17'h10000);
        tick();
        check("t3_min_i", bus.out_i, 17'h10000);
        tick();

        // 6: I/Q together under backpressure
        bus.out_ready = 1'b0;
        send(24'h000180, 24'hFFFE80);
        repeat (3) tick();
        check("t6_valid", bus.out_valid, 1);
        check("t6_out_i", bus.out_i, 17'h00003);
        check("t6_out_q", bus.out_q, 17'h1FFFD);
        bus.out_ready = 1'b1;
        repeat (2) tick();

        // 4: ramp with random backpressure and one 5-cycle stall
        base     = n_out;
        rand_rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) stall_left = 5;
            ramp = 24'(i) << 7;
            send(ramp, 24'd0 - ramp);
        end
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        check("t4_drained", exp_q.size(), 0);
        check("t4_count", n_out - base, 256);
        check("t4_idle_valid", bus.out_valid, 0);

        // 5: reset mid-stream discards in-flight samples
        send(24'h000080, 24'h000000);
        send(24'h000100, 24'h000000);
        send(24'h000200, 24'h000000);
        bus.in_i     = 24'h000280;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        #1;
        check("t5_async_valid", bus.out_valid, 0);
        check("t5_async_out_i", bus.out_i, 0);
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_no_stale", bus.out_valid, 0);
        send(24'h000180, 24'h000180);
        check("t5_lat_early", bus.out_valid, 0);
        tick();
        check("t5_valid", bus.out_valid, 1);
        check("t5_out_i", bus.out_i, 17'h00003);
        check("t5_out_q", bus.out_q, 17'h00003);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
